// File: rtl/epp_host_if.sv
`default_nettype none
// ============================================================================
//  Module      : epp_host_if
//  Description : EPP bus bundle between an EPP initiator (master) and an EPP
//                responder (slave). The bidirectional EppDB pad is carried as
//                its split form: EppDB_o/EppDB_oe from the initiator and
//                EppDB_i toward it. The board-level pad resolves as
//                EppDB = EppDB_oe ? EppDB_o : 'z, with the responder driving
//                the pad only while the initiator has released it.
//  Signals     : EppAstb  address strobe, active low   (master -> slave)
//                EppDstb  data strobe, active low      (master -> slave)
//                EppWR    0 = write, 1 = read          (master -> slave)
//                EppWait  responder handshake, async   (slave  -> master)
//                EppDB_o  initiator write byte         (master -> slave)
//                EppDB_oe initiator drives the bus     (master -> slave)
//                EppDB_i  bus value seen by initiator  (slave  -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface epp_host_if;
    logic       EppAstb;
    logic       EppDstb;
    logic       EppWR;
    logic       EppWait;
    logic [7:0] EppDB_o;
    logic       EppDB_oe;
    logic [7:0] EppDB_i;

    modport master (
        output EppAstb, EppDstb, EppWR, EppDB_o, EppDB_oe,
        input  EppWait, EppDB_i
    );

    modport slave (
        input  EppAstb, EppDstb, EppWR, EppDB_o, EppDB_oe,
        output EppWait, EppDB_i
    );
endinterface
`default_nettype wire

// File: rtl/epp_host.sv
`default_nettype none
// ============================================================================
//  Module      : epp_host
//  Description : EPP initiator. Accepts one bus command at a time on a
//                valid/ready interface, runs the four-phase strobe/Wait
//                handshake on the EPP bus and returns read data (or a timeout
//                flag when EPP_HOST_TIMEOUT_EN is defined).
//  Parameters  : SETUP_CYCLES   clocks EppDB/EppWR are stable before strobe falls
//                TIMEOUT_CYCLES max clocks waited per handshake phase
//                SYNC_STAGES    flops synchronising EppWait
//  Macro       : EPP_HOST_TIMEOUT_EN - enables per-phase handshake timeout;
//                when undefined the handshake waits indefinitely and
//                rsp_timeout is tied low.
//  Ports       : clk, reset (sync, active high)
//                cmd_valid/cmd_ready/cmd_addr/cmd_write/cmd_data  command in
//                rsp_valid/rsp_data/rsp_timeout                   response out
//                busy                                             ~cmd_ready
//                epp (epp_host_if.master)                         EPP bus
//  Revision    : 1.0  initial release
// ============================================================================
module epp_host #(
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int SYNC_STAGES    = 2
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       cmd_valid,
    output logic            cmd_ready,
    input  wire logic       cmd_addr,
    input  wire logic       cmd_write,
    input  wire logic [7:0] cmd_data,
    output logic            rsp_valid,
    output logic [7:0]      rsp_data,
    output logic            rsp_timeout,
    output logic            busy,
    epp_host_if.master      epp
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (SETUP_CYCLES < 1) begin : g_chk_setup
        $error("epp_host: SETUP_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
        $error("epp_host: TIMEOUT_CYCLES must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("epp_host: SYNC_STAGES must be >= 2");
    end

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_STROBE  = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam int                 SETUP_W    = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(SETUP_CYCLES - 1);

    logic [2:0]         state_q,     state_d;
    logic [SETUP_W-1:0] setup_cnt_q, setup_cnt_d;
    logic               sel_addr_q,  sel_addr_d;
    logic               write_q,     write_d;
    logic               astb_q,      astb_d;
    logic               dstb_q,      dstb_d;
    logic               wr_q,        wr_d;
    logic [7:0]         db_o_q,      db_o_d;
    logic               db_oe_q,     db_oe_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [7:0]         rsp_data_q,  rsp_data_d;
    logic [SYNC_STAGES-1:0] sync_q,  sync_d;
    logic               wait_s;

`ifdef EPP_HOST_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q,      to_cnt_d;
    logic            rsp_timeout_q, rsp_timeout_d;
`endif

    // EppWait is asynchronous to clk; only the synchronised copy is used.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], epp.EppWait};
    assign wait_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        setup_cnt_d = setup_cnt_q;
        sel_addr_d  = sel_addr_q;
        write_d     = write_q;
        astb_d      = astb_q;
        dstb_d      = dstb_q;
        wr_d        = wr_q;
        db_o_d      = db_o_q;
        db_oe_d     = db_oe_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
`ifdef EPP_HOST_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    sel_addr_d  = cmd_addr;
                    write_d     = cmd_write;
                    wr_d        = ~cmd_write;
                    db_o_d      = cmd_write ? cmd_data : 8'h00;
                    db_oe_d     = cmd_write;
                    setup_cnt_d = '0;
                    rsp_data_d  = 8'h00;
`ifdef EPP_HOST_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                    state_d     = S_SETUP;
                end
            end
            S_SETUP: begin
                if (setup_cnt_q == SETUP_LAST) begin
                    if (sel_addr_q) begin
                        astb_d = 1'b0;
                    end else begin
                        dstb_d = 1'b0;
                    end
`ifdef EPP_HOST_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                    state_d = S_STROBE;
                end else begin
                    setup_cnt_d = setup_cnt_q + 1'b1;
                end
            end
            // The first wait_s decision happens one edge after the strobe
            // falls, so even a stale-high Wait yields a strobe of >= 1 clk.
            S_STROBE: begin
                if (wait_s) begin
                    if (!write_q) begin
                        rsp_data_d = epp.EppDB_i;
                    end
                    astb_d  = 1'b1;
                    dstb_d  = 1'b1;
`ifdef EPP_HOST_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                    state_d = S_RELEASE;
                end
`ifdef EPP_HOST_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    astb_d        = 1'b1;
                    dstb_d        = 1'b1;
                    db_oe_d       = 1'b0;
                    db_o_d        = 8'h00;
                    wr_d          = 1'b1;
                    rsp_data_d    = 8'h00;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            // Write data stays on the bus until the responder drops Wait.
            S_RELEASE: begin
                if (!wait_s) begin
                    db_oe_d     = 1'b0;
                    db_o_d      = 8'h00;
                    wr_d        = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
`ifdef EPP_HOST_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    db_oe_d       = 1'b0;
                    db_o_d        = 8'h00;
                    wr_d          = 1'b1;
                    rsp_data_d    = 8'h00;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            setup_cnt_q <= '0;
            sel_addr_q  <= 1'b0;
            write_q     <= 1'b0;
            astb_q      <= 1'b1;
            dstb_q      <= 1'b1;
            wr_q        <= 1'b1;
            db_o_q      <= 8'h00;
            db_oe_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            sync_q      <= '0;
`ifdef EPP_HOST_TIMEOUT_EN
            to_cnt_q      <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            setup_cnt_q <= setup_cnt_d;
            sel_addr_q  <= sel_addr_d;
            write_q     <= write_d;
            astb_q      <= astb_d;
            dstb_q      <= dstb_d;
            wr_q        <= wr_d;
            db_o_q      <= db_o_d;
            db_oe_q     <= db_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            sync_q      <= sync_d;
`ifdef EPP_HOST_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign busy         = ~cmd_ready;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
`ifdef EPP_HOST_TIMEOUT_EN
    assign rsp_timeout  = rsp_timeout_q;
`else
    assign rsp_timeout  = 1'b0;
`endif

    assign epp.EppAstb  = astb_q;
    assign epp.EppDstb  = dstb_q;
    assign epp.EppWR    = wr_q;
    assign epp.EppDB_o  = db_o_q;
    assign epp.EppDB_oe = db_oe_q;

endmodule
`default_nettype wire
